set_multi_counter: RTL and testbench

Parametrised successor to the 2015 circle-set counter. Accepts up to three circles (A, B, C) on a GRID×GRID lattice, evaluates all three membership predicates in one raster pass, and reports the number of lattice points satisfying the selected set expression. Sits behind the same `en`/`busy`/`valid` host handshake as the earlier block. Adds union and three-circle modes, and scans once instead of once per circle.

---
 rtl/set_multi_counter.sv | 144 ++++++++++++++
 tb/tb_set_multi_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/set_multi_counter.sv
// Raster-scans a GRID x GRID lattice once per job and counts the points satisfying a set expression over three circles.
// Optional SET_RESULT_HOLD_EN: valid is held from OUT until the next job is accepted instead of pulsing for one cycle.
module set_multi_counter #(
    parameter int GRID = 8,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [6*CW-1:0]   central,
    input  logic [3*CW-1:0]   radius,
    input  logic [2:0]        mode,
    output logic              busy,
    output logic              valid,
    output logic [2*CW:0]     candidate
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, SCAN = 2'd2, OUT = 2'd3} state_t;

    localparam logic [CW-1:0] GMAX = CW'(GRID);
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [2*CW:0]     cnt_q, cnt_d, cand_q, cand_d;
    logic              valid_q, valid_d;
    logic [6*CW-1:0]   central_q, central_d;
    logic [3*CW-1:0]   radius_q, radius_d;
    logic [2:0]        mode_q, mode_d;
    logic              in_a, in_b, in_c, hit;

    // Differences are sign-extended before squaring so the product never wraps.
    function automatic logic in_circle(input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                       input logic [CW-1:0] r, input logic [CW-1:0] px,
                                       input logic [CW-1:0] py);
        logic signed [CW:0]     dx, dy;
        logic signed [2*CW+1:0] dxe, dye;
        logic [2*CW+1:0]        sqx, sqy;
        logic [2*CW+2:0]        sum;
        logic [2*CW-1:0]        r2;
        dx  = $signed({1'b0, cx}) - $signed({1'b0, px});
        dy  = $signed({1'b0, cy}) - $signed({1'b0, py});
        dxe = {{(CW+1){dx[CW]}}, dx};
        dye = {{(CW+1){dy[CW]}}, dy};
        sqx = $unsigned(dxe * dxe);
        sqy = $unsigned(dye * dye);
        sum = {1'b0, sqx} + {1'b0, sqy};
        r2  = {{CW{1'b0}}, r} * {{CW{1'b0}}, r};
        return sum <= {3'b000, r2};
    endfunction

    always_comb begin
        in_a = in_circle(central_q[6*CW-1 -: CW], central_q[5*CW-1 -: CW],
                         radius_q[3*CW-1 -: CW], x_q, y_q);
        in_b = in_circle(central_q[4*CW-1 -: CW], central_q[3*CW-1 -: CW],
                         radius_q[2*CW-1 -: CW], x_q, y_q);
        in_c = in_circle(central_q[2*CW-1 -: CW], central_q[CW-1 -: CW],
                         radius_q[CW-1 -: CW], x_q, y_q);
        case (mode_q)
            3'd0:    hit = in_a;
            3'd1:    hit = in_a & in_b;
            3'd2:    hit = in_a ^ in_b;
            3'd3:    hit = in_a | in_b;
            3'd4:    hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
            3'd5:    hit = in_a & in_b & in_c;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        case (state_q)
            IDLE: state_d = READ;
            READ: begin
                if (en) begin
                    state_d   = SCAN;
                    central_d = central;
                    radius_d  = radius;
                    mode_d    = mode;
                    cnt_d     = '0;
                    x_d       = ONE;
                    y_d       = ONE;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + {{(2*CW){1'b0}}, hit};
                if (x_q == GMAX) begin
                    x_d = ONE;
                    if (y_q == GMAX) begin
                        state_d = OUT;
                        cand_d  = cnt_d;
                    end else begin
                        y_d = y_q + ONE;
                    end
                end else begin
                    x_d = x_q + ONE;
                end
            end
            OUT:     state_d = READ;
            default: state_d = IDLE;
        endcase
`ifdef SET_RESULT_HOLD_EN
        valid_d = (state_d == OUT) || (valid_q && (state_d == READ));
`else
        valid_d = (state_d == OUT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= ONE;
            y_q       <= ONE;
            cnt_q     <= '0;
            cand_q    <= '0;
            valid_q   <= 1'b0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            valid_q   <= valid_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
        end
    end

    assign busy      = (state_q != READ);
    assign valid     = valid_q;
    assign candidate = cand_q;

endmodule

// File: tb/tb_set_multi_counter.sv
// Directed bench for set_multi_counter (GRID=8, CW=4); follows SET_RESULT_HOLD_EN if defined.
module tb_set_multi_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [2:0]  mode;
    logic        busy;
    logic        valid;
    logic [8:0]  candidate;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef SET_RESULT_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    set_multi_counter #(.GRID(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for READ, drives the job and lets edge k sample en.
    task automatic start_job(input logic [3:0] xa, input logic [3:0] ya, input logic [3:0] ra,
                             input logic [3:0] xb, input logic [3:0] yb, input logic [3:0] rb,
                             input logic [3:0] xc, input logic [3:0] yc, input logic [3:0] rc,
                             input logic [2:0] m);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        check("wait_read", {31'd0, busy}, 32'd0);
        central = {xa, ya, xb, yb, xc, yc};
        radius  = {ra, rb, rc};
        mode    = m;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        check("busy_after_en", {31'd0, busy}, 32'd1);
    endtask

    // done = edges already elapsed after edge k; valid appears after edge k+64.
    task automatic finish_job(input string tag, input int exp, input int done);
        repeat (63 - done) tick();
        check({tag, "_novalid_early"}, {31'd0, valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check({tag, "_count"}, {23'd0, candidate}, exp);
        tick();
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_cand", {23'd0, candidate}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_to_read", {31'd0, busy}, 32'd0);

        start_job(4'd4, 4'd4, 4'd2, 4'd7, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 3'd0);
        finish_job("m0_disc", 13, 0);

        // Back-to-back jobs: en lands in the first READ cycle each time.
        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 3'd1);
        finish_job("m1_and", 2, 0);
        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 3'd2);
        finish_job("m2_xor", 6, 0);
        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 3'd3);
        finish_job("m3_or", 8, 0);

        start_job(4'd1, 4'd1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        finish_job("clip_corner", 11, 0);
        start_job(4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        finish_job("r0_edge", 1, 0);
        start_job(4'd0, 4'd0, 4'd0, 4'd3, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 3'd0);
        finish_job("off_grid", 0, 0);

        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd8, 4'd8, 4'd0, 3'd4);
        finish_job("m4_two", 2, 0);
        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd3, 4'd3, 4'd0, 3'd5);
        finish_job("m5_all", 1, 0);
        start_job(4'd3, 4'd3, 4'd1, 4'd4, 4'd3, 4'd1, 4'd3, 4'd3, 4'd0, 3'd6);
        finish_job("m6_rsvd", 0, 0);
        start_job(4'd4, 4'd4, 4'd7, 4'd4, 4'd4, 4'd7, 4'd4, 4'd4, 4'd7, 3'd7);
        finish_job("m7_rsvd", 0, 0);

        // Reset during scan cycle 20 discards the job.
        start_job(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_cand", {23'd0, candidate}, 32'd0);
        seen = 0;
        repeat (100) begin
            tick();
            if (valid === 1'b1) seen++;
        end
        check("midrst_no_valid", seen, 0);
        check("midrst_read", {31'd0, busy}, 32'd0);
        start_job(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        finish_job("after_rst", 13, 0);

        // rst beats en when both are high in READ.
        rst = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        check("rst_en_busy", {31'd0, busy}, 32'd1);
        tick();
        check("rst_en_read", {31'd0, busy}, 32'd0);

        // en during SCAN with other inputs is ignored.
        start_job(4'd4, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        repeat (10) tick();
        central = {4'd1, 4'd1, 4'd5, 4'd5, 4'd2, 4'd2};
        radius  = {4'd6, 4'd6, 4'd6};
        mode    = 3'd3;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        finish_job("en_ignored", 13, 11);

        // Result-hold behaviour across idle READ cycles.
        check("hold_read0", {31'd0, valid}, {31'd0, HOLD});
        check("hold_cand0", {23'd0, candidate}, 32'd13);
        repeat (5) tick();
        check("hold_read5", {31'd0, valid}, {31'd0, HOLD});
        check("hold_cand5", {23'd0, candidate}, 32'd13);
        central = {4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
        radius  = {4'd2, 4'd0, 4'd0};
        mode    = 3'd0;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        check("hold_drop", {31'd0, valid}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
